// File: rtl/lsu_subword.sv
// lsu_subword: RV32I load/store unit in front of a word-wide data memory with a
// registered read port and an edge-triggered write port. Sub-word stores are done
// as read-modify-write. Optional build macro LSU_MISALIGN_TRAP_EN traps misaligned
// halfword/word accesses instead of force-aligning them.
module lsu_subword (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        load_valid,
    output logic [31:0] load_data,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        misalign_err,
`endif
    output logic [31:0] mem_read_addr,
    input  logic [31:0] mem_read_data,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable
);

    typedef enum logic [1:0] {StIdle, StRdIssue, StRdWait, StWrite} state_e;
    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

    state_e      state;
    size_e       size_q;
    logic        store_q;
    logic        unsigned_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;

    size_e       req_size;
    logic        req_unsigned;
    logic [31:0] req_addr_fixed;
    logic        start_access;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] merged;

`ifdef LSU_MISALIGN_TRAP_EN
    logic req_misaligned;
    logic trap;
`endif

    // Decode the incoming request: access size, extension, and the address it really uses.
    always_comb begin
        req_size = SzWord;
        unique case (req_funct3)
            3'b000, 3'b100: req_size = SzByte;
            3'b001, 3'b101: req_size = SzHalf;
            default:        req_size = SzWord;
        endcase
        // BU/HU on a store behave as B/H, so unsigned only matters for loads.
        req_unsigned = req_funct3[2] && !req_store;
        req_addr_fixed = req_addr;
        if (req_size == SzHalf) req_addr_fixed[0] = 1'b0;
        if (req_size == SzWord) req_addr_fixed[1:0] = 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
        req_misaligned = ((req_size == SzHalf) && req_addr[0]) ||
                         ((req_size == SzWord) && (req_addr[1:0] != 2'b00));
        trap           = req_valid && req_ready && req_misaligned;
        start_access   = req_valid && req_ready && !req_misaligned;
`else
        start_access   = req_valid && req_ready;
`endif
    end

    // Lane extraction/extension for loads and lane merge for sub-word stores.
    always_comb begin
        byte_lane = mem_read_data[{lane_q, 3'b000} +: 8];
        half_lane = mem_read_data[{lane_q[1], 4'b0000} +: 16];
        load_ext  = mem_read_data;
        unique case (size_q)
            SzByte:  load_ext = unsigned_q ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            SzHalf:  load_ext = unsigned_q ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: load_ext = mem_read_data;
        endcase
        merged = mem_read_data;
        unique case (size_q)
            SzByte:  merged[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
            SzHalf:  merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Request sequencer; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= StIdle;
            req_ready        <= 1'b1;
            load_valid       <= 1'b0;
            load_data        <= 32'b0;
            mem_read_addr    <= 32'b0;
            mem_write_addr   <= 32'b0;
            mem_write_data   <= 32'b0;
            mem_write_enable <= 1'b0;
            size_q           <= SzWord;
            store_q          <= 1'b0;
            unsigned_q       <= 1'b0;
            lane_q           <= 2'b00;
            wdata_q          <= 32'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_err     <= 1'b0;
`endif
        end else begin
            load_valid       <= 1'b0;
            mem_write_enable <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_err     <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
`ifdef LSU_MISALIGN_TRAP_EN
                    // Trapped request is consumed without touching memory.
                    if (trap) misalign_err <= 1'b1;
`endif
                    if (start_access) begin
                        size_q         <= req_size;
                        store_q        <= req_store;
                        unsigned_q     <= req_unsigned;
                        lane_q         <= req_addr_fixed[1:0];
                        wdata_q        <= req_wdata;
                        req_ready      <= 1'b0;
                        mem_write_addr <= {req_addr_fixed[31:2], 2'b00};
                        if (req_store && (req_size == SzWord)) begin
                            mem_write_data   <= req_wdata;
                            mem_write_enable <= 1'b1;
                            state            <= StWrite;
                        end else begin
                            mem_read_addr <= {req_addr_fixed[31:2], 2'b00};
                            state         <= StRdIssue;
                        end
                    end
                end
                StRdIssue: state <= StRdWait;
                StRdWait: begin
                    if (store_q) begin
                        mem_write_data   <= merged;
                        mem_write_enable <= 1'b1;
                        state            <= StWrite;
                    end else begin
                        load_data  <= load_ext;
                        load_valid <= 1'b1;
                        req_ready  <= 1'b1;
                        state      <= StIdle;
                    end
                end
                StWrite: begin
                    req_ready <= 1'b1;
                    state     <= StIdle;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_subword.md
# lsu_subword

Load/store unit between the execute stage and the word-wide data memory. Accepts RV32I load/store requests (LB/LH/LW/LBU/LHU, SB/SH/SW), drives the memory's registered-read / edge-write word port, and produces sign- or zero-extended load results. Sub-word stores become read-modify-write sequences, because the data memory only writes full 32-bit words.

## Interface
Parameters:
- none.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
  - Other codes are treated as W.
  - BU/HU with `req_store` = 1 are treated as B/H.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; low byte or halfword is used for B/H.
- `load_valid`  out  1  one-cycle pulse; `load_data` is valid while it is high.
- `load_data`  out  32  extended load result; holds its value until the next load.
- `misalign_err`  out  1  one-cycle pulse. Exists only with `LSU_MISALIGN_TRAP_EN` defined.
- `mem_read_addr`  out  32  word-aligned byte address; low 2 bits are always 0.
- `mem_read_data`  in  32  memory output, valid one cycle after the memory samples `mem_read_addr`.
- `mem_write_addr`  out  32  word-aligned byte address.
- `mem_write_data`  out  32  full word to write.
- `mem_write_enable`  out  1  write strobe.

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, WRITE.
- Request fields are captured into registers on accept.
- All outputs are registered.
- Reset values: state IDLE, `req_ready` 1, `load_valid` 0, `load_data` 0, `misalign_err` 0, all `mem_*` outputs 0.
- Load path: IDLE → RD_ISSUE → RD_WAIT → IDLE.
  - In RD_WAIT, select a lane from `mem_read_data` using `addr[1:0]`, little-endian.
  - Byte lane k occupies bits [8k+7:8k]; halfword lane uses `addr[1]`.
  - Extend the lane (sign for B/H, zero for BU/HU), register it into `load_data`, and set `load_valid` for one cycle.
- SW path: IDLE → WRITE → IDLE.
  - In WRITE: `mem_write_enable` = 1, `mem_write_addr` = aligned address, `mem_write_data` = `req_wdata`.
- SB/SH path: IDLE → RD_ISSUE → RD_WAIT → WRITE → IDLE.
  - In RD_WAIT, merge the new byte or halfword into `mem_read_data` at the lane selected by `addr[1:0]`, then register the merged word.
  - In WRITE, write the merged word.
- The block never asserts a read and a write to memory in the same cycle, so there is no read/write collision.
- `mem_write_enable` is 1 only in WRITE. `mem_read_addr` holds its last value outside RD_ISSUE.
- Reset mid-operation: the sequence is abandoned and no write is issued after the reset edge. This applies even if reset lands in RD_WAIT of an SB/SH, so the memory word stays unchanged.
- A request presented while `req_ready` = 0 is ignored. The upstream stage holds it.

## Timing
Cycle 0 is the cycle in which the accepting edge occurs at its end.
- LW/LH/LB: `mem_read_addr` valid in cycle 1; `mem_read_data` valid in cycle 2; `load_valid` high in cycle 3. `req_ready` is low in cycles 1–2 and high in cycle 3.
  - A new request can be accepted in cycle 3, giving a throughput of 1 load per 3 cycles.
- SW: write strobe in cycle 1; `req_ready` high in cycle 2.
- SB/SH: read in cycle 1, merge in cycle 2, write strobe in cycle 3; `req_ready` high in cycle 4.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misalignment conditions: H/HU with `addr[0]` = 1, or W with `addr[1:0]` ≠ 0.
  - A misaligned request is accepted, then goes IDLE → IDLE with `misalign_err` high in cycle 1.
  - No memory access occurs and `load_valid` does not pulse.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - The `misalign_err` port is absent.
  - Misaligned addresses are force-aligned: H clears bit 0, W clears bits [1:0]. Access then proceeds normally.

## Test plan
The bench pairs the block with a data memory model that has a 1-cycle registered read and writes on the clock edge.
- SW 0x10 data 0xDEADBEEF, then LW 0x10 → `load_data` = 0xDEADBEEF, with `load_valid` in cycle 3 and a single write strobe in cycle 1.
- SB 0x11 data 0x000000AA → word 0x10 = 0xDEADAAEF. Then LB 0x11 → 0xFFFFFFAA, and LBU 0x11 → 0x000000AA.
- SH 0x12 data 0x00001234 → word = 0x1234AAEF. Then LH 0x12 → 0x00001234, LH 0x10 → 0xFFFFAAEF, and LHU 0x10 → 0x0000AAEF.
- LW 0x13:
  - With the macro: `misalign_err` pulses in cycle 1, there are no `mem_*` strobes, and `req_ready` = 1 in cycle 1.
  - Without the macro: `load_data` = word at 0x10.
- Assert `rst` for one edge during RD_WAIT of SB 0x14 → no write strobe follows, word 0x14 is unchanged, and `req_ready` = 1 after reset.
- Hold `req_valid` high with three back-to-back SW requests → each is accepted only in IDLE, exactly 3 write strobes occur, at cycles 1, 3 and 5.
